if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the program counter, issues one-outstanding-request fetches to instruction memory over a ready/valid handshake, and applies branch/jump redirects. Each returned instruction is presented as a registered (pc, pc+4, inst, valid) bundle that the IF/ID register captures whenever `stall` is low.

## Interface
- `ADDR_WIDTH`, 64, PC and memory address width
- `INST_WIDTH`, 32, instruction width
- `RESET_PC`, 64'h0, PC value loaded by reset
- `NOP_INST`, 32'h00000013, value driven on `f_inst` after reset

Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `stall`  in  1  downstream not accepting; same signal that holds IF/ID
- `redirect_valid`  in  1  taken branch, jump or trap; one-cycle pulse
- `redirect_pc`  in  ADDR_WIDTH  redirect target
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  ADDR_WIDTH  fetch address, always equal to the current PC
- `imem_ready`  in  1  memory accepts the request this cycle
- `imem_rvalid`  in  1  response data valid
- `imem_rdata`  in  INST_WIDTH  response instruction
- `f_valid`  out  1  output bundle holds a live instruction
- `f_pc`  out  ADDR_WIDTH  PC of the presented instruction
- `f_pc4`  out  ADDR_WIDTH  `f_pc` + 4
- `f_inst`  out  INST_WIDTH  presented instruction

## Operation
- The PC register drives `imem_addr`. A redirect loads it with `redirect_pc` with bits [1:0] forced to 0.
- PC arithmetic is `pc + 4` modulo 2^ADDR_WIDTH. Wrap-around is silent.
- State machine has three states: FETCH, WAIT, DROP.
- **FETCH**
  - `imem_req = ~redirect_valid & ~(f_valid & stall)`.
  - On request accepted (`imem_req & imem_ready`): `req_pc <= pc`, `pc <= pc + 4`, go to WAIT.
  - `redirect_valid`: PC loads the target. No request is issued that cycle. Stay in FETCH.
- **WAIT**
  - `imem_req = 0`.
  - `imem_rvalid & ~redirect_valid`: capture the response into the output bundle and go to FETCH.
    - `f_pc <= req_pc`, `f_pc4 <= req_pc + 4`, `f_inst <= imem_rdata`, `f_valid <= 1`.
  - `redirect_valid` with `imem_rvalid` in the same cycle: discard the response, load the PC, go to FETCH.
  - `redirect_valid` without `imem_rvalid`: load the PC, go to DROP.
- **DROP**
  - `imem_req = 0`.
  - `imem_rvalid`: discard the response and go to FETCH.
  - A further `redirect_valid`: reload the PC and stay in DROP.
- **Output bundle**
  - The bundle is consumed when `f_valid & ~stall`. After consumption `f_valid <= 0` unless a new capture occurs in the same cycle.
  - While `f_valid & stall`, the bundle holds its value and no new request is issued, so no response can arrive and be lost.
  - `redirect_valid` clears `f_valid` on the next edge, regardless of `stall`.
  - A redirect does not clear `f_pc`, `f_pc4` or `f_inst`.
- `imem_rvalid` in FETCH has no outstanding request and is ignored.

## Timing
- **Reset values**
  - `imem_req` = 0 while `reset` is high.
  - `imem_addr` = `RESET_PC`.
  - `f_valid` = 0, `f_pc` = 0, `f_pc4` = 0, `f_inst` = `NOP_INST`.
  - State = FETCH.
- **Reset mid-operation:** any outstanding response is abandoned. A later `imem_rvalid` arrives in FETCH and is ignored.
- **Latency:** request accepted at edge N; `imem_rvalid` in the cycle ending at edge N+k (k ≥ 1); `f_valid` is high after edge N+k.
- **Throughput:** peak is one instruction every 2 cycles (k = 1, no stall). The next request is issued in the cycle `f_valid` rises.
- **Redirect latency:** the new `imem_addr` is visible one cycle after the `redirect_valid` cycle. The first request to the target can be accepted that cycle.
- `imem_req` may drop when a redirect or stall arrives. The memory must not assume a request stays asserted once raised.

## Test plan
- **Reset release:** `RESET_PC` = 0x1000, `imem_ready` = 1, 1-cycle memory returning 0xAAAA0001 / 0xAAAA0002.
  - `imem_addr` sequence 0x1000, 0x1004.
  - `f_valid` pulses with (0x1000, 0x1004, 0xAAAA0001), then (0x1004, 0x1008, 0xAAAA0002).
- **Stall hold:** raise `stall` for 5 cycles while `f_valid` = 1.
  - Bundle constant, `imem_req` = 0 throughout.
  - On release, the bundle is consumed once and the next fetch address is the held PC + 4.
- **Redirect in WAIT:** target 0x2003 while a 3-cycle-latency response is pending.
  - Stale response is dropped and never reaches `f_valid`.
  - Next `imem_addr` = 0x2000.
- **Redirect with rvalid in the same cycle:**
  - Response discarded, no DROP state.
  - `imem_addr` = target on the following cycle.
- **Wrap-around:** `RESET_PC` = 0xFFFF_FFFF_FFFF_FFFC.
  - First bundle `f_pc4` = 0.
  - Second `imem_addr` = 0.
- **Asynchronous reset mid-WAIT:**
  - `imem_req` and `f_valid` drop immediately, without waiting for a clock edge.
  - A late `imem_rvalid` after release is ignored.
  - Fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage feeding the IF/ID pipeline register. It owns the
// program counter and keeps at most one fetch outstanding to instruction memory
// over a ready/valid handshake. Branch, jump and trap redirects reload the PC.
// Each returned instruction is presented as a registered
// (f_pc, f_pc4, f_inst, f_valid) bundle. IF/ID captures the bundle in any cycle
// where stall is low.
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   asynchronous, active-high reset
//   stall           in   downstream not accepting (same signal that holds IF/ID)
//   redirect_valid  in   one-cycle pulse: taken branch, jump or trap
//   redirect_pc     in   redirect target (bits [1:0] are ignored)
//   imem_req        out  fetch request valid
//   imem_addr       out  fetch address (always the current PC)
//   imem_ready      in   memory accepts the request this cycle
//   imem_rvalid     in   response data valid
//   imem_rdata      in   response instruction
//   f_valid         out  output bundle holds a live instruction
//   f_pc            out  PC of the presented instruction
//   f_pc4           out  f_pc + 4
//   f_inst          out  presented instruction
// -----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  f_valid,
    output logic [ADDR_WIDTH-1:0] f_pc,
    output logic [ADDR_WIDTH-1:0] f_pc4,
    output logic [INST_WIDTH-1:0] f_inst
);

    // FETCH: may issue a request.
    // WAIT:  one request is outstanding and its response will be used.
    // DROP:  one request is outstanding but a redirect made it stale.
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    // Redirect targets are word aligned. Masking, rather than slicing, keeps
    // every bit of redirect_pc in use.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [ADDR_WIDTH-1:0] req_pc;      // PC of the outstanding request
    logic [ADDR_WIDTH-1:0] target_pc;
    logic                  req_fire;    // request handshake completes this cycle
    logic                  capture;     // live response loads the bundle
    logic                  consume;     // IF/ID takes the bundle this cycle

    assign target_pc = redirect_pc & ALIGN_MASK;
    assign imem_addr = pc;

    // A request is offered only in FETCH, and never in a redirect cycle.
    // It is also held back while a stalled bundle is waiting. This means a
    // response can never arrive while the bundle still holds an instruction
    // that has not been consumed. Reset gates the request directly, so it drops
    // as soon as reset rises.
    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        imem_req = 1'b0;
        if (!reset && (state == ST_FETCH)) begin
            imem_req = ~redirect_valid & ~(f_valid & stall);
        end
    end

    assign req_fire = imem_req & imem_ready;
    assign capture  = (state == ST_WAIT) & imem_rvalid & ~redirect_valid;
    assign consume  = f_valid & ~stall;

    // Next-state and next-PC logic. pc + 4 wraps silently at 2^ADDR_WIDTH.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            ST_FETCH: begin
                // imem_rvalid has no outstanding request here, so it is ignored.
                if (redirect_valid) begin
                    pc_next = target_pc;
                end else if (req_fire) begin
                    pc_next    = pc + PC_STEP;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_next = target_pc;
                    // A response that arrives together with the redirect is
                    // dropped here, so DROP is not needed. Otherwise the
                    // response is still due and must be dropped in DROP.
                    state_next = imem_rvalid ? ST_FETCH : ST_DROP;
                end else if (imem_rvalid) begin
                    state_next = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (redirect_valid) begin
                    pc_next = target_pc;
                end
                if (imem_rvalid) begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge, whatever the order of the
    // statements.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_FETCH;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (req_fire) begin
                req_pc <= pc;
            end
        end
    end

    // Output bundle. A capture sets f_valid. A redirect clears it even under
    // stall. Otherwise consumption clears it. A redirect leaves the payload
    // fields untouched; only f_valid carries liveness.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_valid <= 1'b0;
            f_pc    <= '0;
            f_pc4   <= '0;
            f_inst  <= NOP_INST;
        end else begin
            if (capture) begin
                f_valid <= 1'b1;
                f_pc    <= req_pc;
                f_pc4   <= req_pc + PC_STEP;
                f_inst  <= imem_rdata;
            end else if (redirect_valid) begin
                f_valid <= 1'b0;
            end else if (consume) begin
                f_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Self-checking bench for if_fetch_stage. The bench uses two instances that
// share every input:
//   dut   RESET_PC = 0x1000
//   wdut  RESET_PC = 0xFFFF_FFFF_FFFF_FFFC, used for the PC wrap-around case
// Both instances follow the same handshake timing, so the bench can check both
// against the same table of fetch vectors.
//
// Expected bundles go onto a scoreboard queue when the bench returns a live
// response. They are popped and compared when the bundle is consumed
// (f_valid & ~stall, sampled on the falling edge).
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [63:0] RST_PC  = 64'h0000_0000_0000_1000;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        imem_req;
    logic [63:0] imem_addr;
    logic        f_valid;
    logic [63:0] f_pc;
    logic [63:0] f_pc4;
    logic [31:0] f_inst;

    logic        w_imem_req;
    logic [63:0] w_imem_addr;
    logic        w_f_valid;
    logic [63:0] w_f_pc;
    logic [63:0] w_f_pc4;
    logic [31:0] w_f_inst;

    if_fetch_stage #(
        .ADDR_WIDTH (64),
        .INST_WIDTH (32),
        .RESET_PC   (RST_PC),
        .NOP_INST   (NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .f_valid        (f_valid),
        .f_pc           (f_pc),
        .f_pc4          (f_pc4),
        .f_inst         (f_inst)
    );

    if_fetch_stage #(
        .ADDR_WIDTH (64),
        .INST_WIDTH (32),
        .RESET_PC   (WRAP_PC),
        .NOP_INST   (NOP)
    ) wdut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (w_imem_req),
        .imem_addr      (w_imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .f_valid        (w_f_valid),
        .f_pc           (w_f_pc),
        .f_pc4          (w_f_pc4),
        .f_inst         (w_f_inst)
    );

    typedef struct {
        logic [63:0] pc;
        logic [63:0] pc4;
        logic [31:0] inst;
    } bundle_t;

    typedef struct {
        int          ready_delay;  // cycles with imem_ready low before accept
        int          lat;          // response latency k (>= 1)
        int          stall_cyc;    // stall cycles applied once the bundle is up
        logic [63:0] addr;         // expected fetch address of dut
        logic [63:0] waddr;        // expected fetch address of wdut
    } vec_t;

    bundle_t sb[$];
    vec_t    vecs[5];
    int      n_cmp  = 0;
    int      n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory contents: 0x1000 -> 0xAAAA0001, 0x1004 -> 0xAAAA0002, and so on.
    function automatic logic [31:0] inst_of(input logic [63:0] addr);
        return 32'hAAAA_0000 + addr[33:2] - 32'h0000_03FF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock. On the falling edge, compare a consumed bundle with
    // the scoreboard. Return 1 time unit after the rising edge, where inputs
    // are driven.
    task automatic cycle();
        bundle_t exp;
        @(negedge clk);
        if (!reset && f_valid && !stall) begin
            check("bundle expected by scoreboard", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("bundle f_pc", f_pc, exp.pc);
                check("bundle f_pc4", f_pc4, exp.pc4);
                check("bundle f_inst", 64'(f_inst), 64'(exp.inst));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One complete fetch: optional ready back-pressure, accept, k-cycle
    // latency, response. On return, the new bundle is up (at posedge+2).
    task automatic fetch(input int ready_delay, input int lat, input logic [63:0] addr,
                         input bit chk_w, input logic [63:0] waddr);
        imem_ready = 1'b0;
        for (int i = 0; i < ready_delay; i++) begin
            #1;
            check("req held while not ready", 64'(imem_req), 64'd1);
            check("addr held while not ready", imem_addr, addr);
            cycle();
        end
        imem_ready = 1'b1;
        #1;
        check("fetch req", 64'(imem_req), 64'd1);
        check("fetch addr", imem_addr, addr);
        if (chk_w) check("wrap fetch addr", w_imem_addr, waddr);
        cycle();
        imem_ready = 1'b0;
        for (int i = 1; i < lat; i++) begin
            #1;
            check("no req while waiting", 64'(imem_req), 64'd0);
            cycle();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = inst_of(addr);
        sb.push_back('{addr, addr + 64'd4, inst_of(addr)});
        cycle();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        #1;
        check("f_valid after response", 64'(f_valid), 64'd1);
        if (chk_w) begin
            check("wrap f_valid", 64'(w_f_valid), 64'd1);
            check("wrap f_pc", w_f_pc, waddr);
            check("wrap f_pc4", w_f_pc4, waddr + 64'd4);
        end
    endtask

    initial begin
        // ready_delay, lat, stall_cyc, dut addr, wdut addr
        vecs[0] = '{0, 1, 0, 64'h1000, WRAP_PC};
        vecs[1] = '{0, 1, 5, 64'h1004, 64'h0};
        vecs[2] = '{0, 2, 0, 64'h1008, 64'h4};
        vecs[3] = '{2, 3, 0, 64'h100C, 64'h8};
        vecs[4] = '{1, 1, 0, 64'h1010, 64'hC};

        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_ready     = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;

        // Reset values. imem_ready is high, so a missing reset gate on
        // imem_req would show up here.
        repeat (2) @(posedge clk);
        #1;
        check("reset imem_req", 64'(imem_req), 64'd0);
        check("reset imem_addr", imem_addr, RST_PC);
        check("reset f_valid", 64'(f_valid), 64'd0);
        check("reset f_pc", f_pc, 64'd0);
        check("reset f_pc4", f_pc4, 64'd0);
        check("reset f_inst", 64'(f_inst), 64'(NOP));
        check("reset wrap imem_req", 64'(w_imem_req), 64'd0);
        check("reset wrap imem_addr", w_imem_addr, WRAP_PC);
        check("reset wrap f_inst", 64'(w_f_inst), 64'(NOP));
        reset = 1'b0;

        // Table-driven fetches: reset release, peak throughput, back-pressure,
        // longer latency, stall hold and PC wrap (wdut).
        for (int v = 0; v < 5; v++) begin
            fetch(vecs[v].ready_delay, vecs[v].lat, vecs[v].addr, 1'b1, vecs[v].waddr);
            if (vecs[v].stall_cyc > 0) begin
                stall = 1'b1;
                for (int s = 0; s < vecs[v].stall_cyc; s++) begin
                    #1;
                    check("stall no req", 64'(imem_req), 64'd0);
                    check("stall f_valid held", 64'(f_valid), 64'd1);
                    check("stall f_pc held", f_pc, vecs[v].addr);
                    check("stall f_pc4 held", f_pc4, vecs[v].addr + 64'd4);
                    check("stall f_inst held", 64'(f_inst), 64'(inst_of(vecs[v].addr)));
                    cycle();
                end
                stall = 1'b0;
            end
        end

        // Redirect while a 3-cycle-latency response is pending.
        imem_ready = 1'b1;
        #1;
        check("A req", 64'(imem_req), 64'd1);
        check("A addr", imem_addr, 64'h1014);
        cycle();
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2003;
        #1;
        check("A no req during redirect", 64'(imem_req), 64'd0);
        cycle();
        redirect_valid = 1'b0;
        #1;
        check("A redirect addr aligned", imem_addr, 64'h2000);
        check("A no req while dropping", 64'(imem_req), 64'd0);
        cycle();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        cycle();
        imem_rvalid = 1'b0;
        #1;
        check("A stale response dropped", 64'(f_valid), 64'd0);
        check("A req after drop", 64'(imem_req), 64'd1);
        fetch(0, 1, 64'h2000, 1'b0, 64'h0);

        // Redirect together with imem_rvalid: response dropped, no DROP state.
        imem_ready = 1'b1;
        #1;
        check("B addr", imem_addr, 64'h2004);
        cycle();
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'hBAD0_0001;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000;
        cycle();
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("B response dropped", 64'(f_valid), 64'd0);
        check("B target addr", imem_addr, 64'h3000);
        check("B req next cycle", 64'(imem_req), 64'd1);
        fetch(0, 1, 64'h3000, 1'b0, 64'h0);

        // A redirect under stall clears f_valid. The payload stays unchanged.
        stall = 1'b1;
        #1;
        check("C stalled no req", 64'(imem_req), 64'd0);
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4001;
        cycle();
        redirect_valid = 1'b0;
        #1;
        check("C f_valid cleared", 64'(f_valid), 64'd0);
        check("C f_pc kept", f_pc, 64'h3000);
        check("C f_pc4 kept", f_pc4, 64'h3004);
        check("C f_inst kept", 64'(f_inst), 64'(inst_of(64'h3000)));
        check("C target addr", imem_addr, 64'h4000);
        check("C req with no live bundle", 64'(imem_req), 64'd1);
        check("C discarded bundle pending", 64'(sb.size()), 64'd1);
        sb.delete();
        stall = 1'b0;
        fetch(0, 1, 64'h4000, 1'b0, 64'h0);

        // Asynchronous reset with a live bundle. The outputs must drop before
        // any clock edge.
        #1;
        reset = 1'b1;
        #1;
        check("D1 req drops async", 64'(imem_req), 64'd0);
        check("D1 f_valid drops async", 64'(f_valid), 64'd0);
        check("D1 addr async", imem_addr, RST_PC);
        check("D1 f_inst async", 64'(f_inst), 64'(NOP));
        check("D1 discarded bundle pending", 64'(sb.size()), 64'd1);
        sb.delete();
        cycle();

        // Asynchronous reset in WAIT. A late response arrives after release.
        reset      = 1'b0;
        imem_ready = 1'b1;
        #1;
        check("D2 req after release", 64'(imem_req), 64'd1);
        check("D2 addr after release", imem_addr, RST_PC);
        cycle();
        imem_ready = 1'b0;
        #1;
        check("D2 in wait", 64'(imem_req), 64'd0);
        #1;
        reset = 1'b1;
        #1;
        check("D2 f_valid in reset", 64'(f_valid), 64'd0);
        check("D2 addr in reset", imem_addr, RST_PC);
        cycle();
        reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0002;
        #1;
        check("D2 fetch state after reset", 64'(imem_req), 64'd1);
        cycle();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        #1;
        check("D2 late response ignored", 64'(f_valid), 64'd0);
        fetch(0, 1, RST_PC, 1'b1, WRAP_PC);
        cycle();
        check("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
